// File: rtl/oram_client_pkg.sv
// Shared types and geometry for the ORAM host client.
package oramPkg;

   localparam int unsigned BYTE_WIDTH      = 8;
   localparam int unsigned BYTES_PER_BLOCK = 4;
   localparam int unsigned TREE_DEPTH      = 8;
   localparam int unsigned DATA_W          = BYTE_WIDTH * BYTES_PER_BLOCK;

   typedef struct packed {
      logic                  write;
      logic [TREE_DEPTH-1:0] block;
      logic [DATA_W-1:0]     data;
   } oram_req_t;

   localparam int unsigned REQ_W = $bits(oram_req_t);

   typedef enum logic [2:0] {
      StIdle,
      StRestart,
      StIssue,
      StWait,
      StResp
   } client_state_t;

endpackage

// File: rtl/oram_client_req_fifo.sv
// Synchronous request queue with full/empty flags; head entry is visible on rdata.
module oram_req_fifo
   import oramPkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [REQ_W-1:0] wdata,
   input  logic             pop,
   output logic [REQ_W-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_MAX = AW'(DEPTH - 1);

   logic [REQ_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= (wptr_q == PTR_MAX) ? '0 : wptr_q + 1'b1;
         end
         if (do_pop) begin
            rptr_q <= (rptr_q == PTR_MAX) ? '0 : rptr_q + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/oram_client.sv
// Host-side ORAM client: queues requests and runs them one at a time, each preceded
// by an ORAM restart pulse, with a bounded wait for the ORAM result.
module oram_client
   import oramPkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned RESTART_CYCLES = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [TREE_DEPTH-1:0] req_block,
   input  logic [DATA_W-1:0]     req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  rsp_write,
   output logic                  rsp_error,
   output logic [TREE_DEPTH-1:0] oram_block_num,
   output logic [DATA_W-1:0]     oram_write_val,
   output logic                  oram_rw_indicator,
   output logic                  oram_input_ready,
   output logic                  oram_rst,
   input  logic [DATA_W-1:0]     oram_read_val,
   input  logic                  oram_output_ready
);

   localparam int unsigned RW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [RW-1:0] RMAX = RW'(RESTART_CYCLES - 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   client_state_t     state_q, state_d;
   oram_req_t         op_q, req_in, fifo_rdata;
   logic [RW-1:0]     rcnt_q;
   logic [TW-1:0]     tcnt_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_error_q;
   logic              fifo_full, fifo_empty, fifo_pop, in_resp;

   assign req_in   = '{write: req_write, block: req_block, data: req_data};
   assign fifo_pop = (state_q == StIdle) && !fifo_empty;
   assign in_resp  = (state_q == StResp);

   oram_req_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (req_valid && req_ready),
      .wdata(req_in),
      .pop  (fifo_pop),
      .rdata(fifo_rdata),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (!fifo_empty) state_d = StRestart;
         StRestart: if (rcnt_q == RMAX) state_d = StIssue;
         StIssue:   state_d = StWait;
         StWait:    if (oram_output_ready || tcnt_q == TMAX) state_d = StResp;
         StResp:    if (rsp_ready) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Operation register and counters; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= '0;
         rcnt_q      <= '0;
         tcnt_q      <= '0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (fifo_pop) begin
                  op_q   <= fifo_rdata;
                  rcnt_q <= '0;
               end
            end
            StRestart: if (rcnt_q != RMAX) rcnt_q <= rcnt_q + 1'b1;
            StIssue:   tcnt_q <= '0;
            StWait: begin
               if (oram_output_ready) begin
                  rsp_data_q  <= op_q.write ? '0 : oram_read_val;
                  rsp_error_q <= 1'b0;
               end else if (tcnt_q == TMAX) begin
                  rsp_data_q  <= '0;
                  rsp_error_q <= 1'b1;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      req_ready         = !rst && !fifo_full;
      oram_rst          = rst || (state_q == StRestart);
      oram_input_ready  = (state_q == StIssue) || (state_q == StWait);
      oram_block_num    = op_q.block;
      oram_rw_indicator = op_q.write;
      // Reads present zero so a previous write's data is never forwarded.
      oram_write_val    = op_q.write ? op_q.data : '0;
      rsp_valid         = in_resp;
      rsp_data          = in_resp ? rsp_data_q : '0;
      rsp_write         = in_resp && op_q.write;
      rsp_error         = in_resp && rsp_error_q;
   end

endmodule

// File: tb/tb_oram_client.sv
// Randomized bench for oram_client with a behavioural ORAM and an in-order scoreboard.
module tb_oram_client;
   import oramPkg::*;

   localparam int unsigned FD = 4;
   localparam int unsigned RC = 2;
   localparam int unsigned TO = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  req_valid, req_ready, req_write;
   logic [TREE_DEPTH-1:0] req_block;
   logic [DATA_W-1:0]     req_data;
   logic                  rsp_valid, rsp_ready, rsp_write, rsp_error;
   logic [DATA_W-1:0]     rsp_data;
   logic [TREE_DEPTH-1:0] oram_block_num;
   logic [DATA_W-1:0]     oram_write_val, oram_read_val;
   logic                  oram_rw_indicator, oram_input_ready, oram_rst, oram_output_ready;

   always #5 clk = ~clk;

   oram_client #(
      .FIFO_DEPTH    (FD),
      .RESTART_CYCLES(RC),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_block        (req_block),
      .req_data         (req_data),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_data         (rsp_data),
      .rsp_write        (rsp_write),
      .rsp_error        (rsp_error),
      .oram_block_num   (oram_block_num),
      .oram_write_val   (oram_write_val),
      .oram_rw_indicator(oram_rw_indicator),
      .oram_input_ready (oram_input_ready),
      .oram_rst         (oram_rst),
      .oram_read_val    (oram_read_val),
      .oram_output_ready(oram_output_ready)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Behavioural ORAM: answers model_lat cycles into an operation, memory survives reset.
   bit [DATA_W-1:0] oram_mem [256];
   bit              model_en  = 1'b1;
   int              model_lat = 1;
   bit              m_done;
   int              m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         oram_output_ready <= 1'b0;
         oram_read_val     <= '0;
         m_done            <= 1'b0;
         m_cnt             <= 0;
      end else begin
         oram_output_ready <= 1'b0;
         if (!oram_input_ready) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
         end else if (model_en && !m_done) begin
            if (m_cnt >= model_lat) begin
               oram_output_ready <= 1'b1;
               m_done            <= 1'b1;
               if (oram_rw_indicator) begin
                  oram_mem[oram_block_num] <= oram_write_val;
                  oram_read_val            <= $urandom;
               end else begin
                  check("wval_on_read", oram_write_val, 0);
                  oram_read_val <= oram_mem[oram_block_num];
               end
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   // Reference: each accepted request yields exactly one response, in acceptance order.
   typedef struct {
      logic              w;
      logic [DATA_W-1:0] d;
      logic              e;
   } exp_t;

   exp_t              expq[$];
   bit [DATA_W-1:0]   ref_mem [256];
   bit                exp_timeout = 1'b0;
   int                or_run = 0, ir_run = 0, last_ir = 0, rst_pulses = 0, rsp_count = 0;
   bit                held = 1'b0;
   logic [DATA_W-1:0] h_d, last_rsp_data;
   logic              h_w, h_e;

   always @(negedge clk) begin
      exp_t x;
      if (rst) begin
         expq.delete();
         held   = 1'b0;
         or_run = 0;
         ir_run = 0;
      end else begin
         if (req_valid && req_ready) begin
            if (exp_timeout) begin
               x = '{w: req_write, d: '0, e: 1'b1};
            end else if (req_write) begin
               ref_mem[req_block] = req_data;
               x = '{w: 1'b1, d: '0, e: 1'b0};
            end else begin
               x = '{w: 1'b0, d: ref_mem[req_block], e: 1'b0};
            end
            expq.push_back(x);
         end
         if (oram_rst) begin
            or_run++;
         end else if (or_run != 0) begin
            check("rst_pulse_width", or_run, RC);
            rst_pulses++;
            or_run = 0;
         end
         if (oram_input_ready) begin
            ir_run++;
         end else if (ir_run != 0) begin
            last_ir = ir_run;
            ir_run  = 0;
         end
         if (rsp_valid) begin
            if (held) begin
               check("rsp_data_stable", rsp_data, h_d);
               check("rsp_write_stable", rsp_write, h_w);
               check("rsp_error_stable", rsp_error, h_e);
               check("no_op_during_rsp", {oram_rst, oram_input_ready}, 0);
            end else if (expq.size() == 0) begin
               check("unexpected_rsp", 1, 0);
            end else begin
               check("rsp_write", rsp_write, expq[0].w);
               check("rsp_data", rsp_data, expq[0].d);
               check("rsp_error", rsp_error, expq[0].e);
            end
            if (rsp_ready) begin
               if (expq.size() != 0) void'(expq.pop_front());
               last_rsp_data = rsp_data;
               rsp_count++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               h_d  = rsp_data;
               h_w  = rsp_write;
               h_e  = rsp_error;
            end
         end
      end
   end

   task automatic send(input logic w, input logic [TREE_DEPTH-1:0] b,
                       input logic [DATA_W-1:0] d);
      int n = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_write = w;
      req_block = b;
      req_data  = d;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 2000) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((expq.size() != 0 || rsp_valid) && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (n >= bound) check("idle_timeout", 0, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  p0, c0, acc, n;
      bit  done;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_block = '0;
      req_data  = '0;
      rsp_ready = 1'b1;

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_write", rsp_write, 0);
      check("rst_rsp_error", rsp_error, 0);
      check("rst_input_ready", oram_input_ready, 0);
      check("rst_rw_ind", oram_rw_indicator, 0);
      check("rst_block_num", oram_block_num, 0);
      check("rst_write_val", oram_write_val, 0);
      check("rst_oram_rst", oram_rst, 1);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rel_req_ready", req_ready, 1);
      check("rel_oram_rst", oram_rst, 0);

      // Basic write/write/read sequence.
      p0 = rst_pulses;
      c0 = rsp_count;
      send(1'b1, 8'd1, 32'd2);
      send(1'b1, 8'd3, 32'd10);
      send(1'b0, 8'd1, 32'd0);
      wait_idle(500);
      check("t1_rsp_count", rsp_count - c0, 3);
      check("t1_rst_pulses", rst_pulses - p0, 3);
      check("t1_read_data", last_rsp_data, 2);

      // Silent ORAM: timeout after ISSUE plus TO wait cycles, then normal service.
      model_en    = 1'b0;
      exp_timeout = 1'b1;
      send(1'b0, 8'd1, 32'd0);
      wait_idle(200);
      exp_timeout = 1'b0;
      model_en    = 1'b1;
      check("tmo_input_ready_cycles", last_ir, TO + 1);
      send(1'b0, 8'd3, 32'd0);
      wait_idle(200);
      check("post_tmo_read", last_rsp_data, 10);

      // Reset during WAIT discards the operation.
      model_en = 1'b0;
      c0       = rsp_count;
      send(1'b0, 8'd1, 32'd0);
      n = 0;
      while (!oram_input_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("mid_op_reached", oram_input_ready, 1);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_input_ready", oram_input_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_en = 1'b1;
      repeat (10) @(negedge clk);
      check("flush_no_rsp", rsp_count - c0, 0);
      check("flush_no_op", {oram_input_ready, oram_rst}, 0);
      check("flush_ready", req_ready, 1);
      send(1'b0, 8'd3, 32'd0);
      wait_idle(200);
      check("post_rst_read", last_rsp_data, 10);

      // Fill the queue behind a stalled response, then hold the response 7 cycles.
      rsp_ready = 1'b0;
      c0        = rsp_count;
      acc       = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         req_valid = 1'b1;
         req_write = (acc == 0 || acc == 2 || acc == 5);
         req_block = (acc == 4) ? 8'd3 : (acc == 5) ? 8'd21 : 8'd20;
         req_data  = 32'h100 + 32'(acc);
         @(negedge clk);
         if (req_ready) acc++;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      check("fifo_accepted", acc, 5);
      @(negedge clk);
      check("fifo_full_ready", req_ready, 0);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("stall_rsp_seen", rsp_valid, 1);
      repeat (7) @(negedge clk);
      check("stall_still_full", req_ready, 0);
      check("stall_no_handshake", rsp_count - c0, 0);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_idle(500);
      check("fifo_rsp_count", rsp_count - c0, 5);

      // Random traffic with random latency and random response back-pressure.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               model_lat = $urandom_range(1, 4);
               send(1'($urandom_range(0, 1)), TREE_DEPTH'($urandom_range(0, 7)), $urandom);
            end
            done = 1'b1;
         end
         begin
            int k = 0;
            while ((!done || expq.size() != 0 || rsp_valid) && k < 20000) begin
               @(posedge clk);
               #1 rsp_ready = ($urandom_range(0, 3) != 0);
               k++;
            end
            if (k >= 20000) check("rand_timeout", 0, 1);
         end
      join
      rsp_ready = 1'b1;
      wait_idle(200);
      check("final_queue_empty", expq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
